// File: rtl/mdu_issue_ctrl_pkg.sv
// rtl/mdu_issue_ctrl_pkg.sv - shared types for the MDU issue controller and its request FIFO
package mdu_issue_ctrl_pkg;

  typedef logic [31:0] reg_data_t;

  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA,
    ALU_SLT, ALU_SLTU, ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
    ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
  } decode_alu_op_t;

  typedef struct packed {
    decode_alu_op_t op;
    logic           w32;
    reg_data_t      src1;
    reg_data_t      src2;
    logic [4:0]     tag;
  } mdu_req_t;

  typedef enum logic [1:0] {
    ST_IDLE, ST_BUSY, ST_DRAIN, ST_HOLD
  } mdu_state_t;

endpackage

// File: rtl/mdu_issue_ctrl_fifo.sv
// rtl/mdu_issue_ctrl_fifo.sv - pending-request FIFO (mdu_req_fifo), read-before-write when full
module mdu_req_fifo
  import mdu_issue_ctrl_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     i_clk,
  input  logic     i_rst_n,
  input  logic     i_clr,
  input  logic     i_push,
  input  mdu_req_t i_data,
  input  logic     i_pop,
  output mdu_req_t o_data,
  output logic     o_full,
  output logic     o_empty
);

  localparam int AW = $clog2(DEPTH);

  mdu_req_t    mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  // Extra pointer bit distinguishes full from empty when the indices coincide.
  assign o_empty = (wr_ptr == rd_ptr);
  assign o_full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign do_pop  = i_pop & ~o_empty;
  assign do_push = i_push & (~o_full | do_pop);
  assign o_data  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/mdu_issue_ctrl.sv
// rtl/mdu_issue_ctrl.sv - MDU issue/writeback sequencer; optional result cache via MDU_RESULT_CACHE_EN
module mdu_issue_ctrl
  import mdu_issue_ctrl_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_flush,
  input  logic           i_req_valid,
  output logic           o_req_ready,
  input  decode_alu_op_t i_req_op,
  input  logic           i_req_w32,
  input  reg_data_t      i_req_src1,
  input  reg_data_t      i_req_src2,
  input  logic [4:0]     i_req_tag,
  output logic           o_mdu_e,
  output decode_alu_op_t o_mdu_op,
  output logic           o_mdu_w32,
  output reg_data_t      o_mdu_src1,
  output reg_data_t      o_mdu_src2,
  output logic           o_mdu_flush,
  output logic           o_mdu_stall,
  input  logic           i_mdu_valid,
  input  reg_data_t      i_mdu_dest,
  output logic           o_wb_valid,
  output logic [4:0]     o_wb_tag,
  output reg_data_t      o_wb_data,
  input  logic           i_wb_ready
);

  mdu_state_t state, state_nxt;
  mdu_req_t   req_in, head, lat;
  logic       fifo_full, fifo_empty, push, pop;
  logic       capture, hit_load, cache_hit;
  reg_data_t  cache_res;
  logic       res_valid;
  logic [4:0] res_tag;
  reg_data_t  res_data;

  assign req_in = '{op: i_req_op, w32: i_req_w32, src1: i_req_src1, src2: i_req_src2, tag: i_req_tag};
  assign push   = i_req_valid & o_req_ready & ~i_flush;

  mdu_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (i_flush),
    .i_push  (push),
    .i_data  (req_in),
    .i_pop   (pop),
    .o_data  (head),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

`ifdef MDU_RESULT_CACHE_EN
  logic           cache_valid;
  decode_alu_op_t cache_op;
  logic           cache_w32;
  reg_data_t      cache_src1, cache_src2;

  assign cache_hit = cache_valid && (head.op == cache_op) && (head.w32 == cache_w32) &&
                     (head.src1 == cache_src1) && (head.src2 == cache_src2);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_flush) begin
      cache_valid <= 1'b0;
    end else if (capture) begin
      cache_valid <= 1'b1;
      cache_op    <= lat.op;
      cache_w32   <= lat.w32;
      cache_src1  <= lat.src1;
      cache_src2  <= lat.src2;
      cache_res   <= i_mdu_dest;
    end
  end
`else
  assign cache_hit = 1'b0;
  assign cache_res = '0;
`endif

  // Issue only when the result register is free, so a capture never overwrites an unread result.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    capture   = 1'b0;
    hit_load  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty && !res_valid) begin
          pop = 1'b1;
          if (cache_hit) hit_load = 1'b1;
          else           state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (i_mdu_valid) begin
          capture   = 1'b1;
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: state_nxt = res_valid ? ST_HOLD : ST_IDLE;
      ST_HOLD:  if (!res_valid) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_flush) state <= ST_IDLE;
    else                     state <= state_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)                          lat <= '0;
    else if (pop && !hit_load && !i_flush) lat <= head;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      res_valid <= 1'b0;
      res_tag   <= '0;
      res_data  <= '0;
    end else if (i_flush) begin
      res_valid <= 1'b0;
    end else if (capture) begin
      res_valid <= 1'b1;
      res_tag   <= lat.tag;
      res_data  <= i_mdu_dest;
    end else if (hit_load) begin
      res_valid <= 1'b1;
      res_tag   <= head.tag;
      res_data  <= cache_res;
    end else if (i_wb_ready) begin
      res_valid <= 1'b0;
    end
  end

  assign o_req_ready = ~fifo_full;
  assign o_mdu_e     = (state == ST_BUSY);
  assign o_mdu_op    = lat.op;
  assign o_mdu_w32   = lat.w32;
  assign o_mdu_src1  = lat.src1;
  assign o_mdu_src2  = lat.src2;
  assign o_mdu_flush = i_flush;
  assign o_mdu_stall = res_valid & ~i_wb_ready;
  assign o_wb_valid  = res_valid;
  assign o_wb_tag    = res_tag;
  assign o_wb_data   = res_data;

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// tb/tb_mdu_issue_ctrl.sv - randomized self-checking bench for mdu_issue_ctrl with an MDU responder model
module tb_mdu_issue_ctrl;
  import mdu_issue_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           i_rst_n, i_flush, i_req_valid, o_req_ready, i_req_w32;
  decode_alu_op_t i_req_op, o_mdu_op;
  reg_data_t      i_req_src1, i_req_src2, o_mdu_src1, o_mdu_src2, i_mdu_dest, o_wb_data;
  logic [4:0]     i_req_tag, o_wb_tag;
  logic           o_mdu_e, o_mdu_w32, o_mdu_flush, o_mdu_stall, i_mdu_valid, o_wb_valid, i_wb_ready;

  mdu_issue_ctrl #(.DEPTH(2)) dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_flush(i_flush),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_op(i_req_op), .i_req_w32(i_req_w32),
    .i_req_src1(i_req_src1), .i_req_src2(i_req_src2), .i_req_tag(i_req_tag),
    .o_mdu_e(o_mdu_e), .o_mdu_op(o_mdu_op), .o_mdu_w32(o_mdu_w32), .o_mdu_src1(o_mdu_src1),
    .o_mdu_src2(o_mdu_src2), .o_mdu_flush(o_mdu_flush), .o_mdu_stall(o_mdu_stall),
    .i_mdu_valid(i_mdu_valid), .i_mdu_dest(i_mdu_dest),
    .o_wb_valid(o_wb_valid), .o_wb_tag(o_wb_tag), .o_wb_data(o_wb_data), .i_wb_ready(i_wb_ready)
  );

  typedef struct packed { logic [4:0] tag; reg_data_t data; } wb_t;
  wb_t exp_q[$];
  wb_t obs_q[$];
  int  n_cmp = 0;
  int  n_err = 0;

  decode_alu_op_t mdu_ops [8] = '{ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};

  // MDU responder state: latency -1 means random per operation
  bit             mdu_active = 0, spurious_en = 0, last_strobe = 0;
  int             mdu_cnt = 0, mdu_lat = -1, mdu_starts = 0, unstable = 0;
  decode_alu_op_t m_op;
  logic           m_w32;
  reg_data_t      m_a, m_b;

  function automatic reg_data_t ref_result(input decode_alu_op_t op, input reg_data_t a, input reg_data_t b);
    longint sa, sb, p;
    longint unsigned ua, ub, u;
    reg_data_t r;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    r  = '0;
    case (op)
      ALU_MUL:    begin u = ua * ub; r = u[31:0]; end
      ALU_MULH:   begin p = sa * sb; r = p[63:32]; end
      ALU_MULHSU: begin p = sa * longint'(ub); r = p[63:32]; end
      ALU_MULHU:  begin u = ua * ub; r = u[63:32]; end
      ALU_DIV: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
        else begin p = sa / sb; r = p[31:0]; end
      end
      ALU_DIVU: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else begin u = ua / ub; r = u[31:0]; end
      end
      ALU_REM: begin
        if (b == 0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
        else begin p = sa % sb; r = p[31:0]; end
      end
      ALU_REMU: begin
        if (b == 0) r = a;
        else begin u = ua % ub; r = u[31:0]; end
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic reg_data_t rnd_operand();
    case ($urandom_range(0, 4))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // One clock: run the MDU responder, record handshakes, advance to the next negedge.
  task automatic tick();
    bit strobe;
    wb_t w;
    strobe = 0;
    #1;
    i_mdu_valid = 1'b0;
    i_mdu_dest  = $urandom;
    if (o_mdu_flush || !i_rst_n || !o_mdu_e) mdu_active = 0;
    if (o_mdu_e && !o_mdu_flush && i_rst_n) begin
      if (!mdu_active) begin
        mdu_active = 1; mdu_starts++;
        m_op = o_mdu_op; m_w32 = o_mdu_w32; m_a = o_mdu_src1; m_b = o_mdu_src2;
        mdu_cnt = (mdu_lat < 0) ? int'($urandom_range(0, 4)) : mdu_lat;
      end else if (o_mdu_op !== m_op || o_mdu_w32 !== m_w32 || o_mdu_src1 !== m_a || o_mdu_src2 !== m_b) begin
        unstable++;
      end
      if (mdu_cnt == 0) begin
        i_mdu_valid = 1'b1; i_mdu_dest = ref_result(m_op, m_a, m_b);
        mdu_active = 0; strobe = 1;
      end else mdu_cnt--;
    end else if (spurious_en && !last_strobe && o_mdu_e === 1'b0) begin
      i_mdu_valid = 1'($urandom_range(0, 1));
    end
    last_strobe = strobe;
    if (i_rst_n) begin
      if (o_wb_valid && i_wb_ready) begin
        w.tag = o_wb_tag; w.data = o_wb_data; obs_q.push_back(w);
      end
      if (i_flush) begin
        while (exp_q.size() > obs_q.size()) void'(exp_q.pop_back());
      end else if (i_req_valid && o_req_ready) begin
        w.tag = i_req_tag; w.data = ref_result(i_req_op, i_req_src1, i_req_src2); exp_q.push_back(w);
      end
    end
    @(negedge clk);
  endtask

  task automatic send(input decode_alu_op_t op, input reg_data_t a, input reg_data_t b,
                      input logic [4:0] tag, output int waits);
    i_req_valid = 1'b1; i_req_op = op; i_req_w32 = 1'b0;
    i_req_src1 = a; i_req_src2 = b; i_req_tag = tag;
    waits = 0;
    while (o_req_ready !== 1'b1 && waits < 200) begin tick(); waits++; end
    tick();
    i_req_valid = 1'b0;
  endtask

  task automatic drain(output bit timed_out);
    int n;
    n = 0;
    i_req_valid = 1'b0; i_flush = 1'b0; i_wb_ready = 1'b1;
    while (obs_q.size() < exp_q.size() && n < 300) begin tick(); n++; end
    timed_out = (n >= 300);
    repeat (5) tick();
  endtask

  task automatic clear_sb();
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset();
    int w, n, s0;
    i_rst_n = 1'b0; repeat (2) tick(); i_rst_n = 1'b1;
    n_cmp++; if (o_req_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", o_req_ready); end
    n_cmp++; if (o_mdu_e !== 1'b0) begin n_err++; $display("FAIL reset_mdu_e got %b want 0", o_mdu_e); end
    n_cmp++; if ({o_mdu_op, o_mdu_w32, o_mdu_src1, o_mdu_src2} !== '0) begin
      n_err++; $display("FAIL reset_mdu_operands got %h/%b/%h/%h want 0", o_mdu_op, o_mdu_w32, o_mdu_src1, o_mdu_src2); end
    n_cmp++; if ({o_wb_valid, o_wb_tag, o_wb_data} !== '0) begin
      n_err++; $display("FAIL reset_wb got %b/%h/%h want 0", o_wb_valid, o_wb_tag, o_wb_data); end
    mdu_lat = 20;
    send(ALU_MUL, 32'd3, 32'd4, 5'd9, w);
    n = 0;
    while (o_mdu_e !== 1'b1 && n < 10) begin tick(); n++; end
    n_cmp++; if (o_mdu_e !== 1'b1) begin n_err++; $display("FAIL reset_pre_busy got %b want 1", o_mdu_e); end
    i_rst_n = 1'b0; tick(); i_rst_n = 1'b1;
    clear_sb(); s0 = mdu_starts;
    n_cmp++; if (o_mdu_e !== 1'b0 || o_wb_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_midop got e=%b wbv=%b want 0/0", o_mdu_e, o_wb_valid); end
    repeat (30) tick();
    n_cmp++; if (obs_q.size() != 0 || mdu_starts != s0) begin
      n_err++; $display("FAIL reset_abandon got wb=%0d starts=%0d want 0/%0d", obs_q.size(), mdu_starts, s0); end
  endtask

  task automatic test_mul_latency();
    int w;
    clear_sb(); mdu_lat = 0; i_wb_ready = 1'b1;
    send(ALU_MUL, 32'd6, 32'd7, 5'd5, w);
    n_cmp++; if (o_mdu_e !== 1'b0) begin n_err++; $display("FAIL mul_n1_e got %b want 0", o_mdu_e); end
    tick();
    n_cmp++; if (o_mdu_e !== 1'b1) begin n_err++; $display("FAIL mul_n2_e got %b want 1", o_mdu_e); end
    n_cmp++; if (o_mdu_op !== ALU_MUL || o_mdu_src1 !== 32'd6 || o_mdu_src2 !== 32'd7) begin
      n_err++; $display("FAIL mul_operands got %h/%h/%h want MUL/6/7", o_mdu_op, o_mdu_src1, o_mdu_src2); end
    tick();
    n_cmp++; if (o_wb_valid !== 1'b1 || o_wb_tag !== 5'd5 || o_wb_data !== 32'h0000_002A) begin
      n_err++; $display("FAIL mul_wb got %b/%0d/%h want 1/5/0000002a", o_wb_valid, o_wb_tag, o_wb_data); end
    tick();
    n_cmp++; if (o_wb_valid !== 1'b0) begin n_err++; $display("FAIL mul_wb_clear got %b want 0", o_wb_valid); end
  endtask

  task automatic test_div_by_zero();
    int w; bit to;
    clear_sb(); mdu_lat = -1;
    send(ALU_DIVU, 32'd100, 32'd0, 5'd3, w);
    send(ALU_REMU, 32'd100, 32'd0, 5'd4, w);
    drain(to);
    n_cmp++; if (to || obs_q.size() != 2) begin n_err++; $display("FAIL divz_count got %0d want 2", obs_q.size()); end
    else begin
      n_cmp++; if (obs_q[0] !== {5'd3, 32'hFFFF_FFFF}) begin n_err++; $display("FAIL divu_zero got %h want 3/ffffffff", obs_q[0]); end
      n_cmp++; if (obs_q[1] !== {5'd4, 32'h0000_0064}) begin n_err++; $display("FAIL remu_zero got %h want 4/00000064", obs_q[1]); end
    end
  endtask

  task automatic test_back_to_back();
    int w0, wa, wb, wc, n; bit to;
    logic [4:0] tags [4];
    tags = '{5'd10, 5'd11, 5'd12, 5'd13};
    clear_sb(); mdu_lat = 15; i_wb_ready = 1'b1;
    send(ALU_MULHU, 32'hDEAD_BEEF, 32'h1234_5678, tags[0], w0);
    n = 0;
    while (o_mdu_e !== 1'b1 && n < 10) begin tick(); n++; end
    send(ALU_DIV, 32'hFFFF_FF9C, 32'd7, tags[1], wa);
    send(ALU_REM, 32'hFFFF_FF9C, 32'd7, tags[2], wb);
    n_cmp++; if (o_req_ready !== 1'b0) begin n_err++; $display("FAIL b2b_full_ready got %b want 0", o_req_ready); end
    mdu_lat = -1;
    send(ALU_MULH, 32'h8000_0000, 32'h8000_0000, tags[3], wc);
    n_cmp++; if (wa != 0 || wb != 0) begin n_err++; $display("FAIL b2b_first_two got waits %0d/%0d want 0/0", wa, wb); end
    n_cmp++; if (wc == 0 || wc >= 200) begin n_err++; $display("FAIL b2b_third_wait got %0d want 1..199", wc); end
    drain(to);
    n_cmp++; if (to || obs_q.size() != 4) begin n_err++; $display("FAIL b2b_count got %0d want 4", obs_q.size()); end
    for (int i = 0; i < 4 && i < obs_q.size() && i < exp_q.size(); i++) begin
      n_cmp++; if (obs_q[i].tag !== tags[i] || obs_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL b2b_order[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_wb_backpressure();
    int w, n, s0; bit to; reg_data_t want;
    clear_sb(); mdu_lat = 2; i_wb_ready = 1'b0;
    want = ref_result(ALU_MULHSU, 32'hFFFF_FFFE, 32'h0000_0003);
    send(ALU_MULHSU, 32'hFFFF_FFFE, 32'h0000_0003, 5'd20, w);
    send(ALU_DIVU, 32'd1000, 32'd9, 5'd21, w);
    n = 0;
    while (o_wb_valid !== 1'b1 && n < 50) begin tick(); n++; end
    s0 = mdu_starts;
    for (int c = 0; c < 10; c++) begin
      n_cmp++; if (o_wb_valid !== 1'b1 || o_wb_tag !== 5'd20 || o_wb_data !== want) begin
        n_err++; $display("FAIL bp_hold[%0d] got %b/%0d/%h want 1/20/%h", c, o_wb_valid, o_wb_tag, o_wb_data, want); end
      n_cmp++; if (o_mdu_e !== 1'b0 || o_mdu_stall !== 1'b1) begin
        n_err++; $display("FAIL bp_mdu[%0d] got e=%b stall=%b want 0/1", c, o_mdu_e, o_mdu_stall); end
      tick();
    end
    n_cmp++; if (mdu_starts != s0) begin n_err++; $display("FAIL bp_no_issue got %0d starts want %0d", mdu_starts, s0); end
    mdu_lat = -1;
    drain(to);
    n_cmp++; if (to || obs_q.size() != 2 || exp_q.size() != 2) begin n_err++; $display("FAIL bp_count got %0d want 2", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL bp_result[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_flush();
    int w, n, s0;
    clear_sb(); mdu_lat = 40; i_wb_ready = 1'b1;
    send(ALU_DIV, 32'd1000, 32'd7, 5'd25, w);
    n = 0;
    while (o_mdu_e !== 1'b1 && n < 10) begin tick(); n++; end
    send(ALU_REM, 32'd5, 32'd3, 5'd26, w);
    s0 = mdu_starts;
    i_flush = 1'b1; i_req_valid = 1'b1; i_req_op = ALU_MUL; i_req_src1 = 32'd2; i_req_src2 = 32'd2; i_req_tag = 5'd27;
    #1;
    n_cmp++; if (o_mdu_flush !== 1'b1) begin n_err++; $display("FAIL flush_passthru got %b want 1", o_mdu_flush); end
    tick();
    i_flush = 1'b0; i_req_valid = 1'b0;
    n_cmp++; if (o_mdu_flush !== 1'b0 || o_mdu_e !== 1'b0 || o_wb_valid !== 1'b0 || o_req_ready !== 1'b1) begin
      n_err++; $display("FAIL flush_next got fl=%b e=%b wbv=%b rdy=%b want 0/0/0/1", o_mdu_flush, o_mdu_e, o_wb_valid, o_req_ready); end
    repeat (60) tick();
    n_cmp++; if (obs_q.size() != 0 || mdu_starts != s0) begin
      n_err++; $display("FAIL flush_dropped got wb=%0d starts=%0d want 0/%0d", obs_q.size(), mdu_starts, s0); end
  endtask

  task automatic test_cache();
    int w, s0; bit to;
    clear_sb(); mdu_lat = -1; i_wb_ready = 1'b1;
    send(ALU_MUL, 32'h1234, 32'h10, 5'd1, w);
    drain(to);
    s0 = mdu_starts;
    send(ALU_MUL, 32'h1234, 32'h10, 5'd2, w);
    drain(to);
    n_cmp++; if (to || obs_q.size() != 2) begin n_err++; $display("FAIL cache_count got %0d want 2", obs_q.size()); end
    else begin
      n_cmp++; if (obs_q[1] !== {5'd2, 32'h0001_2340}) begin n_err++; $display("FAIL cache_result got %h want 2/00012340", obs_q[1]); end
    end
`ifdef MDU_RESULT_CACHE_EN
    n_cmp++; if (mdu_starts != s0) begin n_err++; $display("FAIL cache_skip got %0d starts want %0d", mdu_starts, s0); end
`else
    n_cmp++; if (mdu_starts != s0 + 1) begin n_err++; $display("FAIL cache_off_issue got %0d starts want %0d", mdu_starts, s0 + 1); end
`endif
  endtask

  task automatic test_random();
    bit to;
    clear_sb(); mdu_lat = -1; spurious_en = 1; unstable = 0;
    for (int c = 0; c < 600; c++) begin
      i_req_valid = 1'($urandom_range(0, 1));
      i_req_op    = mdu_ops[$urandom_range(0, 7)];
      i_req_w32   = 1'($urandom_range(0, 1));
      i_req_src1  = rnd_operand();
      i_req_src2  = rnd_operand();
      i_req_tag   = 5'($urandom);
      i_wb_ready  = ($urandom_range(0, 3) != 0);
      i_flush     = ($urandom_range(0, 80) == 0);
      tick();
    end
    drain(to);
    spurious_en = 0;
    n_cmp++; if (to || obs_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL rand_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rand_result[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    n_cmp++; if (unstable != 0) begin n_err++; $display("FAIL rand_operand_stable got %0d changes want 0", unstable); end
  endtask

  initial begin
    i_rst_n = 1'b0; i_flush = 1'b0; i_req_valid = 1'b0; i_req_op = ALU_ADD; i_req_w32 = 1'b0;
    i_req_src1 = '0; i_req_src2 = '0; i_req_tag = '0; i_mdu_valid = 1'b0; i_mdu_dest = '0; i_wb_ready = 1'b1;
    test_reset();
    test_mul_latency();
    test_div_by_zero();
    test_back_to_back();
    test_wb_backpressure();
    test_flush();
    test_cache();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
